spike_scheduler: RTL and testbench

SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

---
 rtl/snn_pkg.sv | 21 ++
 rtl/spike_event_fifo.sv | 60 ++++++
 rtl/spike_scheduler.sv | 146 ++++++++++++++
 tb/tb_spike_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spike scheduler.
package snn_pkg;

    localparam int unsigned NREQ_DEFAULT   = 4;
    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 8;
    localparam int unsigned SPIKE_W        = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } schedState_t;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [SPIKE_W-1:0]        spike;
    } spikeEvent_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Event FIFO between the arbiter and the synapse port; head is always visible.
module spike_event_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Push,
    input  logic [WIDTH-1:0] PushData,
    input  logic             Pop,
    output logic [WIDTH-1:0] HeadData,
    output logic             Empty,
    output logic             Full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign Empty    = (count == '0);
    assign Full     = (count == CNT_W'(DEPTH));
    assign doPush   = Push && !Full;
    assign doPop    = Pop && !Empty;
    assign HeadData = mem[rdPtr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            mem[wrPtr] <= PushData;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_scheduler.sv
// Round-robin spike event scheduler: collects requester events per timestep
// into a FIFO and drains them to the synapse.
// Optional build macro SPIKE_SCHED_STATS_EN adds the EventCount output.
module spike_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Tick,
    input  logic [NREQ-1:0]           ReqValid,
    input  logic [NREQ*ADDR_W-1:0]    ReqAddr,
    input  logic [NREQ*SPIKE_W-1:0]   ReqSpike,
    output logic [NREQ-1:0]           ReqReady,
    output logic                      EvValid,
    output logic [ADDR_W-1:0]         EvAddr,
    output logic [SPIKE_W-1:0]        EvSpike,
    input  logic                      EvReady,
    output logic                      Busy,
    output logic                      StepDone,
    output logic                      TickMiss
`ifdef SPIKE_SCHED_STATS_EN
    ,
    output logic [15:0]               EventCount
`endif
);

    localparam int unsigned RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned EV_W = ADDR_W + SPIKE_W;

    schedState_t         state;
    schedState_t         stateNext;
    logic [RR_W-1:0]     rrPtr;
    logic [2*NREQ-1:0]   dblValid;
    logic [NREQ-1:0]     rotValid;
    logic                arbEn;
    logic                grantValid;
    logic [RR_W-1:0]     grantOffset;
    logic [RR_W:0]       laneSum;
    logic [RR_W-1:0]     grantLane;
    logic [NREQ-1:0]     grantOneHot;
    logic [ADDR_W-1:0]   selAddr;
    logic [SPIKE_W-1:0]  selSpike;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                pushEn;
    logic                popEn;
    logic [EV_W-1:0]     headData;

    // Round-robin arbiter: rotate requests so rrPtr is bit 0, pick lowest set bit.
    always_comb begin
        arbEn       = (state == COLLECT) && !fifoFull;
        dblValid    = {ReqValid, ReqValid};
        rotValid    = NREQ'(dblValid >> rrPtr);
        grantValid  = 1'b0;
        grantOffset = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (arbEn && rotValid[k]) begin
                grantValid  = 1'b1;
                grantOffset = RR_W'(k);
            end
        end
        laneSum   = {1'b0, rrPtr} + {1'b0, grantOffset};
        grantLane = (laneSum >= (RR_W+1)'(NREQ)) ? RR_W'(laneSum - (RR_W+1)'(NREQ))
                                                  : RR_W'(laneSum);
        grantOneHot = '0;
        selAddr     = '0;
        selSpike    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantValid && (grantLane == RR_W'(i))) begin
                grantOneHot[i] = 1'b1;
                selAddr        = ReqAddr[i*ADDR_W +: ADDR_W];
                selSpike       = ReqSpike[i*SPIKE_W +: SPIKE_W];
            end
        end
    end

    assign ReqReady = grantOneHot;
    // Zero spike vectors are consumed from the requester but never queued.
    assign pushEn   = grantValid && (selSpike != '0);
    assign popEn    = !fifoEmpty && EvReady;
    assign EvValid  = !fifoEmpty;
    assign {EvAddr, EvSpike} = headData;
    assign Busy     = (state != IDLE);
    assign StepDone = (state == DONE);

    spike_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .Push     (pushEn),
        .PushData ({selAddr, selSpike}),
        .Pop      (popEn),
        .HeadData (headData),
        .Empty    (fifoEmpty),
        .Full     (fifoFull)
    );

    // Timestep sequencing next-state.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Tick)            stateNext = COLLECT;
            COLLECT: if (ReqValid == '0)  stateNext = DRAIN;
            DRAIN:   if (fifoEmpty)       stateNext = DONE;
            DONE:                         stateNext = IDLE;
            default:                      stateNext = IDLE;
        endcase
    end

    // State register, round-robin pointer and sticky missed-tick flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            rrPtr    <= '0;
            TickMiss <= 1'b0;
        end else begin
            state <= stateNext;
            if (grantValid) begin
                rrPtr <= (grantLane == RR_W'(NREQ - 1)) ? '0 : grantLane + RR_W'(1);
            end
            if (Tick && (state != IDLE)) begin
                TickMiss <= 1'b1;
            end
        end
    end

`ifdef SPIKE_SCHED_STATS_EN
    // Saturating count of events handed to the synapse in the current timestep.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            EventCount <= '0;
        end else if ((state == IDLE) && Tick) begin
            EventCount <= '0;
        end else if (popEn && (EventCount != 16'hFFFF)) begin
            EventCount <= EventCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with constant expectations.
module tb_spike_scheduler;
    import snn_pkg::*;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic                    Tick;
    logic [NREQ-1:0]         ReqValid;
    logic [NREQ*ADDR_W-1:0]  ReqAddr;
    logic [NREQ*8-1:0]       ReqSpike;
    logic [NREQ-1:0]         ReqReady;
    logic                    EvValid;
    logic [ADDR_W-1:0]       EvAddr;
    logic [7:0]              EvSpike;
    logic                    EvReady;
    logic                    Busy;
    logic                    StepDone;
    logic                    TickMiss;
`ifdef SPIKE_SCHED_STATS_EN
    logic [15:0]             EventCount;
`endif

    always #5 Clk = ~Clk;

    spike_scheduler #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .ReqValid (ReqValid),
        .ReqAddr  (ReqAddr),
        .ReqSpike (ReqSpike),
        .ReqReady (ReqReady),
        .EvValid  (EvValid),
        .EvAddr   (EvAddr),
        .EvSpike  (EvSpike),
        .EvReady  (EvReady),
        .Busy     (Busy),
        .StepDone (StepDone),
        .TickMiss (TickMiss)
`ifdef SPIKE_SCHED_STATS_EN
        ,
        .EventCount (EventCount)
`endif
    );

    int vecCount  = 0;
    int missCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done.
    int          mPhase;
    int          mRr;
    spikeEvent_t mQ[$];
    bit          mMiss;
    int          mCount;

    // Stimulus: per-lane pending events, plus observation logs.
    spikeEvent_t     laneQ[NREQ][$];
    logic [NREQ-1:0] grantLog[$];
    spikeEvent_t     deliveredLog[$];
    bit              sawDone;
    int              holdGrants;
    logic [NREQ-1:0] holdReady;

    function automatic spikeEvent_t mkEv(input logic [7:0] a, input logic [7:0] s);
        spikeEvent_t e;
        e.addr  = a;
        e.spike = s;
        return e;
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mRr    = 0;
        mQ.delete();
        mMiss  = 1'b0;
        mCount = 0;
    endtask

    task automatic driveLanes();
        for (int i = 0; i < NREQ; i++) begin
            if (laneQ[i].size() > 0) begin
                ReqValid[i] = 1'b1;
                ReqAddr[i*ADDR_W +: ADDR_W] = laneQ[i][0].addr;
                ReqSpike[i*8 +: 8]          = laneQ[i][0].spike;
            end else begin
                ReqValid[i] = 1'b0;
                ReqAddr[i*ADDR_W +: ADDR_W] = 8'($urandom);
                ReqSpike[i*8 +: 8]          = 8'($urandom);
            end
        end
    endtask

    // One clock: drive at negedge, compare against model, advance model at posedge.
    task automatic cycle();
        int              g;
        logic [NREQ-1:0] expReady;
        logic [NREQ-1:0] rvNow;
        spikeEvent_t     gEv;
        bit              emptyNow;
        int              nextPhase;
        driveLanes();
        #1;
        rvNow = ReqValid;
        g = -1;
        if (mPhase == 1 && mQ.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int lane;
                lane = (mRr + k) % NREQ;
                if (g < 0 && rvNow[lane]) g = lane;
            end
        end
        expReady = (g >= 0) ? NREQ'(1) << g : '0;
        checkVal("ReqReady", 32'(ReqReady), 32'(expReady));
        checkVal("EvValid", 32'(EvValid), 32'(mQ.size() > 0));
        if (mQ.size() > 0) checkVal("EvData", 32'({EvAddr, EvSpike}), 32'(mQ[0]));
        checkVal("Busy", 32'(Busy), 32'(mPhase != 0));
        checkVal("StepDone", 32'(StepDone), 32'(mPhase == 3));
        checkVal("TickMiss", 32'(TickMiss), 32'(mMiss));
`ifdef SPIKE_SCHED_STATS_EN
        checkVal("EventCount", 32'(EventCount), 32'(mCount));
`endif
        if (ReqReady != '0) grantLog.push_back(ReqReady);
        if (EvValid && EvReady) deliveredLog.push_back(spikeEvent_t'({EvAddr, EvSpike}));
        if (StepDone) sawDone = 1'b1;
        @(posedge Clk);
        emptyNow  = (mQ.size() == 0);
        nextPhase = mPhase;
        if (!emptyNow && EvReady) begin
            void'(mQ.pop_front());
            if (mCount < 65535) mCount++;
        end
        if (g >= 0) begin
            gEv = laneQ[g].pop_front();
            if (gEv.spike != 8'h00) mQ.push_back(gEv);
            mRr = (g + 1) % NREQ;
        end
        if (Tick && mPhase != 0) mMiss = 1'b1;
        case (mPhase)
            0: if (Tick) begin nextPhase = 1; mCount = 0; end
            1: if (rvNow == '0) nextPhase = 2;
            2: if (emptyNow) nextPhase = 3;
            default: nextPhase = 0;
        endcase
        mPhase = nextPhase;
        @(negedge Clk);
    endtask

    // Assert reset for one cycle (called at a negedge) and check reset outputs.
    task automatic doReset();
        Reset   = 1'b0;
        Tick    = 1'b0;
        EvReady = 1'b0;
        for (int i = 0; i < NREQ; i++) laneQ[i].delete();
        modelReset();
        driveLanes();
        #1;
        checkVal("rstEvValid", 32'(EvValid), 32'(0));
        checkVal("rstReqReady", 32'(ReqReady), 32'(0));
        checkVal("rstBusy", 32'(Busy), 32'(0));
        checkVal("rstStepDone", 32'(StepDone), 32'(0));
        checkVal("rstTickMiss", 32'(TickMiss), 32'(0));
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // One timestep. evMode: 0 random EvReady, 1 always ready, 2 stalled for holdN cycles.
    task automatic runStep(input int evMode, input int holdN, input bit extraTick);
        int n;
        grantLog.delete();
        deliveredLog.delete();
        sawDone = 1'b0;
        holdGrants = 0;
        holdReady  = '0;
        Tick    = 1'b1;
        EvReady = (evMode == 1);
        cycle();
        Tick = 1'b0;
        n = 0;
        while (mPhase != 0 && n < 400) begin
            case (evMode)
                0:       EvReady = ($urandom_range(0, 2) != 0);
                1:       EvReady = 1'b1;
                default: EvReady = (n >= holdN);
            endcase
            Tick = extraTick ? ($urandom_range(0, 15) == 0) : 1'b0;
            if (evMode == 2 && n == holdN) begin
                holdGrants = grantLog.size();
                holdReady  = ReqReady;
            end
            cycle();
            n++;
        end
        Tick = 1'b0;
        #1;
        checkVal("stepIdle", 32'(Busy), 32'(0));
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; Tick = 1'b0; EvReady = 1'b0;
        ReqValid = '0; ReqAddr = '0; ReqSpike = '0;
        @(negedge Clk);
        doReset();

        // Single event on lane 0.
        laneQ[0].push_back(mkEv(8'h05, 8'h81));
        runStep(1, 0, 1'b0);
        checkVal("t1Grants", 32'(grantLog.size()), 32'(1));
        if (grantLog.size() > 0) checkVal("t1Grant", 32'(grantLog[0]), 32'(4'b0001));
        checkVal("t1Delivered", 32'(deliveredLog.size()), 32'(1));
        if (deliveredLog.size() > 0) checkVal("t1Ev", 32'(deliveredLog[0]), 32'(16'h0581));
        checkVal("t1Done", 32'(sawDone), 32'(1));

        // All lanes busy: round-robin order.
        doReset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) laneQ[i].push_back(mkEv(8'(i + 1), 8'(8'h10 + i)));
        runStep(1, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k < grantLog.size()) checkVal("rrGrant", 32'(grantLog[k]), 32'(4'b0001 << (k % 4)));
            if (k < deliveredLog.size()) checkVal("rrAddr", 32'(deliveredLog[k].addr), 32'((k % 4) + 1));
        end
        checkVal("rrCount", 32'(deliveredLog.size()), 32'(8));

        // FIFO full back-pressure: 9 requests into depth 8.
        doReset();
        for (int k = 0; k < 9; k++) laneQ[0].push_back(mkEv(8'(8'h20 + k), 8'(k + 1)));
        runStep(2, 14, 1'b0);
        checkVal("fullGrants", 32'(holdGrants), 32'(8));
        checkVal("fullReady", 32'(holdReady), 32'(0));
        checkVal("fullCount", 32'(deliveredLog.size()), 32'(9));
        for (int k = 0; k < 9; k++)
            if (k < deliveredLog.size()) checkVal("fullOrder", 32'(deliveredLog[k].addr), 32'(8'h20 + k));

        // Zero spike vector is consumed but never delivered.
        doReset();
        laneQ[2].push_back(mkEv(8'h33, 8'h00));
        runStep(1, 0, 1'b0);
        checkVal("zeroGrant", 32'(grantLog.size() > 0 ? grantLog[0] : '0), 32'(4'b0100));
        checkVal("zeroDeliv", 32'(deliveredLog.size()), 32'(0));
        checkVal("zeroDone", 32'(sawDone), 32'(1));

`ifdef SPIKE_SCHED_STATS_EN
        // Event counter: five deliveries, then cleared by the next Tick.
        doReset();
        for (int k = 0; k < 5; k++) laneQ[k % NREQ].push_back(mkEv(8'(k), 8'hA5));
        runStep(1, 0, 1'b0);
        #1;
        checkVal("statCount", 32'(EventCount), 32'(5));
        @(negedge Clk);
        Tick = 1'b1;
        cycle();
        Tick = 1'b0;
        #1;
        checkVal("statClear", 32'(EventCount), 32'(0));
        @(negedge Clk);
        for (int k = 0; k < 3; k++) cycle();
`endif

        // Tick during COLLECT, then reset mid-DRAIN with three events queued.
        doReset();
        for (int k = 0; k < 3; k++) laneQ[0].push_back(mkEv(8'(8'h40 + k), 8'h0F));
        EvReady = 1'b0;
        Tick = 1'b1; cycle();
        Tick = 1'b0; cycle();
        Tick = 1'b1; cycle();
        Tick = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        #1;
        checkVal("missFlag", 32'(TickMiss), 32'(1));
        checkVal("missBusy", 32'(Busy), 32'(1));
        checkVal("drainValid", 32'(EvValid), 32'(1));
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkVal("midRstValid", 32'(EvValid), 32'(0));
        checkVal("midRstBusy", 32'(Busy), 32'(0));
        checkVal("midRstMiss", 32'(TickMiss), 32'(0));
        @(negedge Clk);
        doReset();

        // Randomized timesteps.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++)
                    laneQ[i].push_back(mkEv(8'($urandom),
                                            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255))));
            end
            runStep(0, 0, 1'b1);
            for (int i = 0; i < NREQ; i++) laneQ[i].delete();
            if (s == 20) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
